// File: rtl/gnet_pkg.sv
// Shared types and constants for the six-input gate network checker.
// The expected-output function lives here so the model and any bench agree on one definition.
package gnet_pkg;
  localparam int VEC_W   = 6;
  localparam int NUM_VEC = 64;
  localparam int CNT_W   = 4;
  localparam int ERR_W   = 7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_e;

  // {a,b,c,d,e,f} = v[5:0]; (d & ~d) makes the inner product zero, so this is 1 for every vector
  function automatic logic gnet_expected(input logic [VEC_W-1:0] v);
    return ~(~(v[5] & v[4]) & (v[3] & ~v[2] & v[2]) & ~(v[1] | v[0]));
  endfunction
endpackage

// File: rtl/gnet_ref_model.sv
// Combinational golden model of the gate network: one expected bit per input vector.
module gnet_ref_model
  import gnet_pkg::*;
(
  input  logic [VEC_W-1:0] vec,
  output logic             expected
);
  assign expected = gnet_expected(vec);
endmodule

// File: rtl/vec_drive_check.sv
// Exhaustive 64-vector driver/checker for a six-input gate network.
// Optional feature macro: FAIL_STROBE_EN adds a per-mismatch strobe (fail_stb/fail_vec).
module vec_drive_check
  import gnet_pkg::*;
#(
  parameter int SETTLE_CYCLES = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             y_in,
  output logic [VEC_W-1:0] vec_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
`ifdef FAIL_STROBE_EN
  output logic             fail_stb,
  output logic [VEC_W-1:0] fail_vec,
`endif
  output logic [VEC_W-1:0] first_fail_vec
);
  localparam logic [CNT_W-1:0] RELOAD   = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(NUM_VEC - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = ERR_W'(NUM_VEC);

  state_e           state_q, state_d;
  logic [VEC_W-1:0] vec_q, vec_d, ff_q, ff_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic             expected, mismatch;

  gnet_ref_model u_ref (.vec(vec_q), .expected(expected));

  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    ff_d     = ff_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    pass_d   = pass_q;
    mismatch = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        vec_d   = '0;
        err_d   = '0;
        ff_d    = '0;
        pass_d  = 1'b0;
        busy_d  = 1'b1;
        cnt_d   = RELOAD;
        state_d = SETTLE;
      end
      SETTLE: begin
        if (abort) begin
          busy_d  = 1'b0;
          pass_d  = 1'b0;
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      SAMPLE: begin
        if (abort) begin
          busy_d  = 1'b0;
          pass_d  = 1'b0;
          state_d = IDLE;
        end else begin
          mismatch = (y_in != expected);
          if (mismatch) begin
            if (err_q == '0) ff_d = vec_q;
            if (err_q != ERR_MAX) err_d = err_q + 1'b1;
          end
          if (vec_q != LAST_VEC) begin
            vec_d   = vec_q + 1'b1;
            cnt_d   = RELOAD;
            state_d = SETTLE;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        // done/busy/pass are registered, so they appear as this state is left
        done_d  = 1'b1;
        busy_d  = 1'b0;
        pass_d  = (err_q == '0);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      ff_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      ff_q    <= ff_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

`ifdef FAIL_STROBE_EN
  logic             fail_stb_q, fail_stb_d;
  logic [VEC_W-1:0] fail_vec_q, fail_vec_d;

  always_comb begin
    fail_stb_d = mismatch;
    fail_vec_d = mismatch ? vec_q : fail_vec_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fail_stb_q <= 1'b0;
      fail_vec_q <= '0;
    end else begin
      fail_stb_q <= fail_stb_d;
      fail_vec_q <= fail_vec_d;
    end
  end

  assign fail_stb = fail_stb_q;
  assign fail_vec = fail_vec_q;
`endif

  assign vec_out        = vec_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_fail_vec = ff_q;
endmodule

// File: tb/tb_vec_drive_check.sv
// Randomized bench for vec_drive_check: faults are a 64-bit mask of vectors on which y_in reads 0.
// Expected counts, first failing vector and done latency are derived from the mask and the timing rule.
module tb_vec_drive_check;
  localparam int S       = 3;
  localparam int DONE_AT = 64 * (S + 1) + 1;

  logic        clk = 1'b0;
  logic        rst, start, abort, y_in;
  logic [5:0]  vec_out, first_fail_vec;
  logic        busy, done, pass;
  logic [6:0]  err_count;
`ifdef FAIL_STROBE_EN
  logic        fail_stb;
  logic [5:0]  fail_vec;
`endif
  logic [63:0] fault_mask;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  // network under test: correct output is always 1, faulty vectors read 0
  always_comb y_in = ~fault_mask[vec_out];

  vec_drive_check #(.SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .y_in(y_in),
    .vec_out(vec_out), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count),
`ifdef FAIL_STROBE_EN
    .fail_stb(fail_stb), .fail_vec(fail_vec),
`endif
    .first_fail_vec(first_fail_vec)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic run_full(input logic [63:0] mask, input bit poke_start, input string tag);
    int cyc, nerr, first, stb;
    bit seen, stb_ok;
    nerr = 0; first = 0; stb = 0; stb_ok = 1; seen = 0; cyc = 0;
    for (int v = 63; v >= 0; v--) if (mask[v]) begin nerr++; first = v; end
    fault_mask = mask;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    while (!seen && cyc < DONE_AT + 20) begin
      @(posedge clk);
      cyc++;
      #1 start = (poke_start && cyc == 100);
      @(negedge clk);
      if (cyc == 1) chk({tag, "_vec0"}, 32'(vec_out), 32'd0);
      if (cyc == 50) chk({tag, "_busy_mid"}, 32'(busy), 32'd1);
`ifdef FAIL_STROBE_EN
      if (fail_stb) begin
        stb++;
        if (!mask[fail_vec]) stb_ok = 0;
      end
`endif
      if (done) seen = 1;
    end
    start = 1'b0;
    chk({tag, "_done_cycle"}, 32'(cyc), 32'(DONE_AT));
    chk({tag, "_err"}, 32'(err_count), 32'(nerr));
    chk({tag, "_first"}, 32'(first_fail_vec), 32'(first));
    chk({tag, "_pass"}, 32'(pass), 32'(nerr == 0));
`ifdef FAIL_STROBE_EN
    chk({tag, "_stb_cnt"}, 32'(stb), 32'(nerr));
    chk({tag, "_stb_vec"}, 32'(stb_ok), 32'd1);
`endif
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({tag, "_busy_end"}, 32'(busy), 32'd0);
    chk({tag, "_err_hold"}, 32'(err_count), 32'(nerr));
  endtask

  task automatic wait_vec(input logic [5:0] v, input string tag);
    int n;
    n = 0;
    while (vec_out != v && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_reach_vec"}, 32'(vec_out), 32'(v));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; fault_mask = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_vec", 32'(vec_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pass", 32'(pass), 32'd0);
    chk("rst_err", 32'(err_count), 32'd0);
    chk("rst_first", 32'(first_fail_vec), 32'd0);
    rst = 1'b0;

    run_full(64'd0, 1'b0, "clean");
    run_full(64'd1 << 6'h2A, 1'b0, "single2a");

    // abort mid-run keeps counts, clears pass, no done pulse
    fault_mask = 64'd1 << 3;
    run_full(64'd0, 1'b0, "clean2");
    fault_mask = 64'd1 << 3;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_vec(6'd10, "abort");
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_pass", 32'(pass), 32'd0);
    chk("abort_err", 32'(err_count), 32'd1);
    chk("abort_first", 32'(first_fail_vec), 32'd3);
    repeat (20) begin
      @(negedge clk);
      if (done || busy || vec_out != 6'd10) chk("abort_idle", {done, busy, 24'd0, vec_out}, 32'd10);
    end
    run_full(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, "stuck0");

    // start and abort together in IDLE: start wins
    @(negedge clk) begin start = 1'b1; abort = 1'b1; end
    @(posedge clk);
    #1 begin start = 1'b0; abort = 1'b0; end
    @(negedge clk);
    chk("start_abort_busy", 32'(busy), 32'd1);
    chk("start_abort_vec", 32'(vec_out), 32'd0);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;

    // reset mid-run beats start/abort
    fault_mask = {$urandom, $urandom};
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_vec(6'd40, "rstmid");
    rst = 1'b1; start = 1'b1; abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rstmid_vec", 32'(vec_out), 32'd0);
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_pass", 32'(pass), 32'd0);
    chk("rstmid_err", 32'(err_count), 32'd0);
    chk("rstmid_first", 32'(first_fail_vec), 32'd0);
`ifdef FAIL_STROBE_EN
    chk("rstmid_stb", {fail_stb, 25'd0, fail_vec}, 32'd0);
`endif
    rst = 1'b0; start = 1'b0; abort = 1'b0;

    for (int i = 0; i < 3; i++)
      run_full({$urandom, $urandom} & {$urandom, $urandom}, (i == 1), $sformatf("rand%0d", i));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
